nobl_sram_emu: RTL

Synthesizable responder for the NoBL/ZBT SRAM pin interface, the memory side of the external-FIFO controller. It accepts the controller's RAM_* command pins and reproduces the pipelined 2-cycle ZBT read/write timing against on-chip block RAM. Its uses are builds without the external SRAM fitted and closed-loop regression of the external FIFO path. It also reports bus-protocol errors and access counts for debug.

---
 rtl/nobl_sram_emu.sv | 126 ++++++++++++
 1 files changed

// File: rtl/nobl_sram_emu.sv
// NoBL/ZBT SRAM responder: two-stage pipelined read/write against on-chip RAM,
// with write-to-read forwarding, bus-contention detection and access counters.
module nobl_sram_emu #(
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned RAM_DEPTH = 19,
  parameter int unsigned MEM_DEPTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [RAM_DEPTH-1:0] RAM_A,
  input  logic [WIDTH-1:0]     RAM_D_po,
  input  logic                 RAM_D_poe,
  output logic [WIDTH-1:0]     RAM_D_pi,
  output logic                 RAM_D_drv,
  input  logic                 RAM_WEn,
  input  logic                 RAM_CENn,
  input  logic                 RAM_LDn,
  input  logic                 RAM_OEn,
  input  logic                 RAM_CE1n,
  input  logic                 clr,
  output logic                 contention_err,
  output logic [15:0]          wr_count,
  output logic [15:0]          rd_count
);

  typedef struct packed {
    logic                 valid;
    logic                 we;
    logic [MEM_DEPTH-1:0] addr;
  } stage_t;

  stage_t s1_q, s1_d, s2_q, s2_d;

  logic [WIDTH-1:0] mem_q [2**MEM_DEPTH];
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             out_vld_q, out_vld_d;
  logic             err_q, err_d;
  logic [15:0]      wr_cnt_q, wr_cnt_d;
  logic [15:0]      rd_cnt_q, rd_cnt_d;

  logic advance, accept, wr_commit, rd_commit, fwd;

  // Upper address bits alias onto the implemented array.
  logic unused_addr;
  assign unused_addr = ^RAM_A[RAM_DEPTH-1:MEM_DEPTH];

  assign advance   = ~RAM_CENn;
  assign accept    = advance & ~RAM_CE1n & ~RAM_LDn;
  assign wr_commit = advance & s2_q.valid & s2_q.we;
  assign rd_commit = advance & s2_q.valid & ~s2_q.we;
  assign fwd       = wr_commit & (s2_q.addr == s1_q.addr);

  assign RAM_D_pi       = dout_q;
  assign RAM_D_drv      = out_vld_q & ~RAM_OEn;
  assign contention_err = err_q;
  assign wr_count       = wr_cnt_q;
  assign rd_count       = rd_cnt_q;

  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    rd_data_d = rd_data_q;
    dout_d    = dout_q;
    out_vld_d = out_vld_q;
    err_d     = err_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;

    if (advance) begin
      s2_d = s1_q;
      s1_d = '{valid: accept, we: ~RAM_WEn, addr: RAM_A[MEM_DEPTH-1:0]};
      // A same-address write committing on this edge is not yet in the array.
      if (s1_q.valid && !s1_q.we) begin
        rd_data_d = fwd ? RAM_D_po : mem_q[s1_q.addr];
      end
      out_vld_d = rd_commit;
      if (rd_commit) begin
        dout_d = rd_data_q;
      end
    end

    if (wr_commit) wr_cnt_d = wr_cnt_q + 16'd1;
    if (rd_commit) rd_cnt_d = rd_cnt_q + 16'd1;

    if ((RAM_D_drv && RAM_D_poe) || (wr_commit && !RAM_D_poe)) begin
      err_d = 1'b1;
    end

    if (clr) begin
      err_d    = 1'b0;
      wr_cnt_d = '0;
      rd_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      rd_data_q <= '0;
      dout_q    <= '0;
      out_vld_q <= 1'b0;
      err_q     <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      rd_data_q <= rd_data_d;
      dout_q    <= dout_d;
      out_vld_q <= out_vld_d;
      err_q     <= err_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
    end
  end

  // Array has no reset; an aborted write never commits because reset clears stage2.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem_q[s2_q.addr] <= RAM_D_po;
    end
  end

endmodule
